// File: rtl/backscatter_pkg.sv
// ---------------------------------------------------------------------------
// backscatter_pkg : shared states, modes and preamble constants for the encoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package backscatter_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_PILOT    = 3'd1;
  localparam state_t ST_PREAMBLE = 3'd2;
  localparam state_t ST_DATA     = 3'd3;
  localparam state_t ST_DUMMY    = 3'd4;

  localparam logic [1:0] M_FM0 = 2'b00;
  localparam logic [1:0] M_M2  = 2'b01;
  localparam logic [1:0] M_M4  = 2'b10;
  localparam logic [1:0] M_M8  = 2'b11;

  localparam logic [11:0] FM0_PREAMBLE    = 12'b110100100011;
  localparam logic [5:0]  MILLER_PREAMBLE = 6'b010111;

  localparam logic [4:0] PILOT_FM0_LEN   = 5'd12;
  localparam logic [4:0] PILOT_M_SHORT   = 5'd4;
  localparam logic [4:0] PILOT_M_LONG    = 5'd16;

  // Index of the last half-period in a symbol (L-1, L = 2 for FM0, 2M for Miller)
  function automatic logic [3:0] sym_last(input logic [1:0] m);
    case (m)
      M_FM0: sym_last = 4'd1;
      M_M2:  sym_last = 4'd3;
      M_M4:  sym_last = 4'd7;
      M_M8:  sym_last = 4'd15;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/symbol_timer.sv
// ---------------------------------------------------------------------------
// symbol_timer : half-period counter, symbol-end / mid-symbol strobes, subcarrier
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module symbol_timer
  import backscatter_pkg::*;
(
  input  logic       clk_blf,
  input  logic       rst,
  input  logic       run,
  input  logic [1:0] m_sel,
  output logic       sym_end,
  output logic       mid_next,
  output logic       sc
);

  logic [3:0] r_hp;
  logic [3:0] w_last;

  assign w_last = sym_last(m_sel);

  // Held at 0 while idle so the first half-period of a reply is always hp=0
  always_ff @(posedge clk_blf or posedge rst) begin
    if (rst) begin
      r_hp <= 4'd0;
    end else if (!run || r_hp == w_last) begin
      r_hp <= 4'd0;
    end else begin
      r_hp <= r_hp + 4'd1;
    end
  end

  assign sym_end  = run && (r_hp == w_last);
  assign mid_next = run && (r_hp == (w_last >> 1));
  assign sc       = r_hp[0];

endmodule

`default_nettype wire

// File: rtl/backscatter_encoder.sv
// ---------------------------------------------------------------------------
// backscatter_encoder : FM0 / Miller tag reply serialiser in the 2xBLF domain
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module backscatter_encoder
  import backscatter_pkg::*;
#(
  parameter int unsigned MAX_BITS = 16'd65535
) (
  input  logic       clk_blf,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] m_sel,
  input  logic       trext,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       bit_last,
  output logic       bit_ready,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       done,
  output logic       underrun
);

  localparam int CNT_W = $clog2(MAX_BITS + 1);

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_m_sel;
  logic               r_trext;
  logic [4:0]         r_cnt, w_cnt_nxt;
  logic               r_bit, w_bit_nxt;
  logic               r_final, w_final_nxt;
  logic [CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic               r_b, w_b_nxt;
  logic               r_tx, w_tx_nxt;
  logic               r_done, w_done_nxt;

  logic       w_sym_end, w_mid_next, w_sc, w_sc_nxt;
  logic       w_fm0, w_start, w_ready;
  logic [4:0] w_pilot_last;

  symbol_timer u_timer (
    .clk_blf  (clk_blf),
    .rst      (rst),
    .run      (r_state != ST_IDLE),
    .m_sel    (r_m_sel),
    .sym_end  (w_sym_end),
    .mid_next (w_mid_next),
    .sc       (w_sc)
  );

  assign w_fm0        = (r_m_sel == M_FM0);
  assign w_start      = start && (r_state == ST_IDLE) && !r_done;
  assign w_sc_nxt     = w_sym_end ? 1'b0 : ~w_sc;
  assign w_pilot_last = w_fm0   ? PILOT_FM0_LEN - 5'd1 :
                        r_trext ? PILOT_M_LONG - 5'd1 : PILOT_M_SHORT - 5'd1;
  assign w_ready      = w_sym_end &&
                        ((r_state == ST_PREAMBLE && r_cnt == 5'd5) ||
                         (r_state == ST_DATA && !r_final));

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_nxt     = r_bit;
    w_final_nxt   = r_final;
    w_bit_cnt_nxt = r_bit_cnt;
    w_b_nxt       = r_b;
    w_tx_nxt      = r_tx;
    w_done_nxt    = 1'b0;
    if (r_state == ST_IDLE) begin
      w_b_nxt  = 1'b0;
      w_tx_nxt = 1'b0;
      if (w_start) begin
        w_state_nxt   = (m_sel == M_FM0 && !trext) ? ST_PREAMBLE : ST_PILOT;
        w_cnt_nxt     = 5'd0;
        w_bit_nxt     = 1'b0;
        w_final_nxt   = 1'b0;
        w_bit_cnt_nxt = '0;
        // FM0 opens with a boundary inversion away from the idle 0 level
        w_b_nxt       = (m_sel == M_FM0);
        w_tx_nxt      = w_b_nxt;
      end
    end else begin
      if (w_sym_end) begin
        case (r_state)
          ST_PILOT: begin
            if (r_cnt == w_pilot_last) begin
              w_state_nxt = ST_PREAMBLE;
              w_cnt_nxt   = 5'd0;
              w_bit_nxt   = MILLER_PREAMBLE[5];
            end else begin
              w_cnt_nxt   = r_cnt + 5'd1;
            end
          end
          ST_PREAMBLE: begin
            if (r_cnt != 5'd5) begin
              w_cnt_nxt = r_cnt + 5'd1;
              w_bit_nxt = MILLER_PREAMBLE[3'd4 - r_cnt[2:0]];
            end
          end
          ST_DATA: begin
            if (r_final) begin
              w_state_nxt = ST_DUMMY;
              w_bit_nxt   = 1'b1;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        endcase
        if (w_ready) begin
          if (bit_valid) begin
            w_state_nxt   = ST_DATA;
            w_bit_nxt     = bit_in;
            w_final_nxt   = bit_last || (r_bit_cnt == CNT_W'(MAX_BITS - 1));
            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          end else begin
            w_state_nxt   = ST_DUMMY;
            w_bit_nxt     = 1'b1;
          end
        end
        if (w_fm0 || (!r_bit && !w_bit_nxt)) begin
          w_b_nxt = ~r_b;
        end
      end else if (w_mid_next && (w_fm0 ? !r_bit : r_bit)) begin
        w_b_nxt = ~r_b;
      end
      // The FM0 preamble carries a deliberate violation, so it is replayed verbatim
      if (w_fm0 && w_state_nxt == ST_PREAMBLE) begin
        w_b_nxt = FM0_PREAMBLE[4'd11 - {w_cnt_nxt[2:0], w_sc_nxt}];
      end
      w_tx_nxt = w_fm0 ? w_b_nxt : (w_b_nxt ^ w_sc_nxt);
      if (w_state_nxt == ST_IDLE) begin
        w_b_nxt  = 1'b0;
        w_tx_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_blf or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_m_sel   <= M_FM0;
      r_trext   <= 1'b0;
      r_cnt     <= 5'd0;
      r_bit     <= 1'b0;
      r_final   <= 1'b0;
      r_bit_cnt <= '0;
      r_b       <= 1'b0;
      r_tx      <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit     <= w_bit_nxt;
      r_final   <= w_final_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_b       <= w_b_nxt;
      r_tx      <= w_tx_nxt;
      r_done    <= w_done_nxt;
      if (w_start) begin
        r_m_sel <= m_sel;
        r_trext <= trext;
      end
    end
  end

  assign tx_out    = r_tx;
  assign done      = r_done;
  assign tx_busy   = (r_state != ST_IDLE);
  assign bit_ready = w_ready;
  assign underrun  = w_ready && !bit_valid;

endmodule

`default_nettype wire

// File: tb/tb_backscatter_encoder.sv
// ---------------------------------------------------------------------------
// tb_backscatter_encoder : randomized replies checked against a half-period model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_backscatter_encoder;

  logic       clk_blf = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] m_sel;
  logic       trext;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_last;
  logic       bit_ready;
  logic       tx_out;
  logic       tx_busy;
  logic       done;
  logic       underrun;

  int vectors = 0;
  int miscompares = 0;

  logic exp_tx[$];
  logic exp_rdy[$];
  logic exp_und[$];
  logic tx_bits [64];

  backscatter_encoder #(.MAX_BITS(8)) dut (
    .clk_blf   (clk_blf),
    .rst       (rst),
    .start     (start),
    .m_sel     (m_sel),
    .trext     (trext),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_last  (bit_last),
    .bit_ready (bit_ready),
    .tx_out    (tx_out),
    .tx_busy   (tx_busy),
    .done      (done),
    .underrun  (underrun)
  );

  always #5 clk_blf = ~clk_blf;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Expected half-period levels of a whole reply, derived symbol by symbol
  task automatic build_model(input logic [1:0] m, input logic tr, input int n, input logic trunc);
    int syms[$];
    int L, npilot, nrdy, pre_end, prev;
    logic lvl, rdy;
    logic [11:0] pat;
    logic [5:0]  mpre;
    pat  = 12'b110100100011;
    mpre = 6'b010111;
    exp_tx.delete(); exp_rdy.delete(); exp_und.delete();
    L      = 2 << m;
    npilot = (m == 2'd0) ? (tr ? 12 : 0) : (tr ? 16 : 4);
    for (int i = 0; i < npilot; i++) syms.push_back(0);
    if (m == 2'd0) syms.push_back(2);
    else for (int i = 5; i >= 0; i--) syms.push_back(int'(mpre[i]));
    pre_end = syms.size() - 1;
    for (int i = 0; i < n; i++) syms.push_back(int'(tx_bits[i]));
    syms.push_back(1);
    nrdy = trunc ? n + 1 : n;
    lvl  = 1'b0;
    prev = -1;
    foreach (syms[s]) begin
      if (syms[s] == 2) begin
        for (int i = 11; i >= 0; i--) begin
          lvl = pat[i];
          exp_tx.push_back(lvl); exp_rdy.push_back(1'b0); exp_und.push_back(1'b0);
        end
      end else if (m == 2'd0) begin
        lvl = ~lvl;
        exp_tx.push_back(lvl); exp_rdy.push_back(1'b0); exp_und.push_back(1'b0);
        if (syms[s] == 0) lvl = ~lvl;
        exp_tx.push_back(lvl); exp_rdy.push_back(1'b0); exp_und.push_back(1'b0);
      end else begin
        if (prev == 0 && syms[s] == 0) lvl = ~lvl;
        for (int h = 0; h < L; h++) begin
          if (h == L / 2 && syms[s] == 1) lvl = ~lvl;
          exp_tx.push_back(lvl ^ (h % 2 == 1)); exp_rdy.push_back(1'b0); exp_und.push_back(1'b0);
        end
      end
      prev = syms[s];
      rdy  = (s >= pre_end) && (s < pre_end + nrdy);
      exp_rdy[exp_rdy.size() - 1] = rdy;
      exp_und[exp_und.size() - 1] = trunc && (s == pre_end + nrdy - 1);
    end
  endtask

  task automatic drive_bits(input int k, input int n, input logic trunc, input logic no_last);
    bit_valid = (k < n) || no_last;
    bit_in    = tx_bits[k % 64];
    bit_last  = !trunc && !no_last && (k == n - 1);
  endtask

  // Plays one reply, comparing every half-period; optional start pokes mid-reply and on done
  task automatic play_reply(input logic [1:0] m, input logic tr, input int n, input logic trunc,
                            input logic no_last, input int poke_idx, input logic poke_done,
                            output int rdy_cnt);
    int k, nhp, L;
    logic xfer;
    build_model(m, tr, n, trunc);
    nhp = exp_tx.size();
    L = 2 << m;
    k = 0;
    rdy_cnt = 0;
    @(negedge clk_blf);
    m_sel = m; trext = tr; start = 1'b1;
    drive_bits(k, n, trunc, no_last);
    @(posedge clk_blf); #1;
    start = 1'b0;
    m_sel = 2'($urandom);
    trext = 1'($urandom);
    for (int i = 0; i < nhp; i++) begin
      @(negedge clk_blf);
      vectors += 5;
      if (tx_out !== exp_tx[i]) begin
        miscompares++; $display("FAIL tx_out m=%0d hp#%0d got %b want %b", m, i, tx_out, exp_tx[i]);
      end
      if (bit_ready !== exp_rdy[i]) begin
        miscompares++; $display("FAIL bit_ready m=%0d hp#%0d got %b want %b", m, i, bit_ready, exp_rdy[i]);
      end
      if (underrun !== exp_und[i]) begin
        miscompares++; $display("FAIL underrun m=%0d hp#%0d got %b want %b", m, i, underrun, exp_und[i]);
      end
      if (tx_busy !== 1'b1) begin
        miscompares++; $display("FAIL tx_busy hp#%0d got %b want 1", i, tx_busy);
      end
      if (done !== 1'b0) begin
        miscompares++; $display("FAIL early_done hp#%0d got %b want 0", i, done);
      end
      xfer = bit_ready && bit_valid;
      if (bit_ready) rdy_cnt++;
      if (i == poke_idx) start = 1'b1;
      @(posedge clk_blf); #1;
      start = 1'b0;
      if (xfer) k++;
      drive_bits(k, n, trunc, no_last);
    end
    @(negedge clk_blf);
    vectors += 5;
    if (done !== 1'b1) begin miscompares++; $display("FAIL done_pulse got %b want 1", done); end
    if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL busy_at_done got %b want 0", tx_busy); end
    if (tx_out !== 1'b0) begin miscompares++; $display("FAIL tx_idle_at_done got %b want 0", tx_out); end
    if (bit_ready !== 1'b0) begin miscompares++; $display("FAIL ready_at_done got %b want 0", bit_ready); end
    if (k !== n) begin miscompares++; $display("FAIL bits_taken got %0d want %0d", k, n); end
    if (poke_done) start = 1'b1;
    @(posedge clk_blf); #1;
    start = 1'b0;
    bit_valid = 1'b0;
    for (int i = 0; i < 2 * L + 2; i++) begin
      @(negedge clk_blf);
      vectors += 3;
      if (done !== 1'b0) begin miscompares++; $display("FAIL extra_done cyc%0d got %b want 0", i, done); end
      if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL extra_busy cyc%0d got %b want 0", i, tx_busy); end
      if (tx_out !== 1'b0) begin miscompares++; $display("FAIL idle_tx cyc%0d got %b want 0", i, tx_out); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; m_sel = 2'd0; trext = 1'b0;
    bit_in = 1'b0; bit_valid = 1'b0; bit_last = 1'b0;
    repeat (3) @(negedge clk_blf);
    vectors += 5;
    if (tx_out !== 1'b0) begin miscompares++; $display("FAIL reset_tx got %b want 0", tx_out); end
    if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", tx_busy); end
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    if (bit_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", bit_ready); end
    if (underrun !== 1'b0) begin miscompares++; $display("FAIL reset_underrun got %b want 0", underrun); end
    rst = 1'b0;
  endtask

  task automatic test_fm0_basic();
    int rc;
    tx_bits[0] = 1'b1; tx_bits[1] = 1'b0; tx_bits[2] = 1'b1;
    play_reply(2'd0, 1'b0, 3, 1'b0, 1'b0, -1, 1'b0, rc);
    vectors++;
    if (rc !== 3) begin miscompares++; $display("FAIL fm0_ready_pulses got %0d want 3", rc); end
  endtask

  task automatic test_fm0_pilot();
    int rc;
    tx_bits[0] = 1'b0;
    play_reply(2'd0, 1'b1, 1, 1'b0, 1'b0, -1, 1'b0, rc);
    vectors++;
    if (rc !== 1) begin miscompares++; $display("FAIL fm0_pilot_ready_pulses got %0d want 1", rc); end
  endtask

  task automatic test_m2_zeros();
    int rc;
    tx_bits[0] = 1'b0; tx_bits[1] = 1'b0;
    play_reply(2'd1, 1'b0, 2, 1'b0, 1'b0, -1, 1'b0, rc);
    vectors++;
    if (rc !== 2) begin miscompares++; $display("FAIL m2_ready_pulses got %0d want 2", rc); end
  endtask

  task automatic test_m8_underrun();
    int rc;
    play_reply(2'd3, 1'b1, 0, 1'b1, 1'b0, -1, 1'b0, rc);
    vectors++;
    if (rc !== 1) begin miscompares++; $display("FAIL m8_underrun_ready got %0d want 1", rc); end
  endtask

  task automatic test_overflow();
    int rc;
    for (int i = 0; i < 64; i++) tx_bits[i] = 1'($urandom);
    play_reply(2'd0, 1'b0, 8, 1'b0, 1'b1, -1, 1'b0, rc);
    vectors++;
    if (rc !== 8) begin miscompares++; $display("FAIL overflow_ready got %0d want 8", rc); end
  endtask

  task automatic test_reset_mid();
    int rc;
    @(negedge clk_blf);
    m_sel = 2'd2; trext = 1'b0; start = 1'b1;
    bit_valid = 1'b1; bit_last = 1'b0; bit_in = 1'($urandom);
    @(posedge clk_blf); #1;
    start = 1'b0;
    repeat (90) begin
      @(posedge clk_blf); #1;
      bit_in = 1'($urandom);
    end
    #2;
    vectors++;
    if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL busy_before_abort got %b want 1", tx_busy); end
    rst = 1'b1;
    #1;
    vectors += 4;
    if (tx_out !== 1'b0) begin miscompares++; $display("FAIL abort_tx got %b want 0", tx_out); end
    if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", tx_busy); end
    if (bit_ready !== 1'b0) begin miscompares++; $display("FAIL abort_ready got %b want 0", bit_ready); end
    if (done !== 1'b0) begin miscompares++; $display("FAIL abort_done got %b want 0", done); end
    @(posedge clk_blf); #2;
    rst = 1'b0;
    bit_valid = 1'b0;
    repeat (2) @(posedge clk_blf);
    for (int i = 0; i < 4; i++) tx_bits[i] = 1'($urandom);
    play_reply(2'd2, 1'b0, 4, 1'b0, 1'b0, -1, 1'b0, rc);
  endtask

  task automatic test_back_to_back();
    int rc, n;
    n = $urandom_range(1, 4);
    for (int i = 0; i < n; i++) tx_bits[i] = 1'($urandom);
    play_reply(2'd1, 1'b0, n, 1'b0, 1'b0, 10, 1'b1, rc);
    vectors++;
    if (rc !== n) begin miscompares++; $display("FAIL b2b_ready got %0d want %0d", rc, n); end
  endtask

  task automatic test_random();
    int rc, n;
    logic [1:0] m;
    logic tr, trunc;
    for (int r = 0; r < 8; r++) begin
      m     = 2'($urandom);
      tr    = 1'($urandom);
      trunc = 1'($urandom);
      n     = $urandom_range(1, 6);
      for (int i = 0; i < 64; i++) tx_bits[i] = 1'($urandom);
      play_reply(m, tr, n, trunc, 1'b0, -1, 1'b0, rc);
      vectors++;
      if (rc !== (trunc ? n + 1 : n)) begin
        miscompares++; $display("FAIL rand_ready m=%0d got %0d want %0d", m, rc, trunc ? n + 1 : n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fm0_basic();
    test_fm0_pilot();
    test_m2_zeros();
    test_m8_underrun();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
